// File: rtl/seven_seg_scan_display.sv
// Purpose: time-multiplexed N-digit hex seven-segment driver with guard blanking and leading-zero suppression.
// Latency: seg/dp/dig_sel are registered, one cycle behind div_cnt/dig_idx/shadow; shadow loads on the load edge.
// Backpressure: none; load/enable are sampled every cycle, enable=0 freezes the scan and darkens the display.
module seven_seg_scan_display #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 1024,
   parameter int GUARD        = 16,
   parameter int COMMON_ANODE = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_done
);

   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = $clog2(SCAN_DIV);

   localparam logic [CW-1:0]         DIV_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]         GUARD_C  = CW'(GUARD);
   localparam logic [DW-1:0]         IDX_LAST = DW'(NUM_DIGITS - 1);
   localparam logic                  INV      = (COMMON_ANODE != 0);
   localparam logic [6:0]            SEG_OFF  = {7{INV}};
   localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{INV}};
   localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1);

   typedef enum logic {
      ST_SCAN = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic                    scan_act;

   logic [4*NUM_DIGITS-1:0] shadow_val;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [CW-1:0]           div_cnt;
   logic [DW-1:0]           dig_idx;

   logic [NUM_DIGITS-1:0]   lz_blank;
   logic                    zero_run;
   logic [3:0]              cur_nib;
   logic                    guard_act;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;
   logic [NUM_DIGITS-1:0]   dig_nxt;
   logic                    frame_nxt;

   // Active-high gfedcba pattern for one hex nibble.
   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0: pat = 7'h3F;
         4'h1: pat = 7'h06;
         4'h2: pat = 7'h5B;
         4'h3: pat = 7'h4F;
         4'h4: pat = 7'h66;
         4'h5: pat = 7'h6D;
         4'h6: pat = 7'h7D;
         4'h7: pat = 7'h07;
         4'h8: pat = 7'h7F;
         4'h9: pat = 7'h6F;
         4'hA: pat = 7'h77;
         4'hB: pat = 7'h7C;
         4'hC: pat = 7'h39;
         4'hD: pat = 7'h5E;
         4'hE: pat = 7'h79;
         default: pat = 7'h71;
      endcase
      return pat;
   endfunction

   // Shadow register: captures the display value whenever load is high, regardless of enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
      end else if (load) begin
         shadow_val <= value;
         shadow_dp  <= dp_in;
      end
   end

   // SCAN/HALT state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_HALT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state follows enable; the cycle's activity uses the next state so halting takes effect on the same edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SCAN: if (!enable) state_d = ST_HALT;
         ST_HALT: if (enable)  state_d = ST_SCAN;
         default: state_d = ST_HALT;
      endcase
      scan_act = (state_d == ST_SCAN);
   end

   // Dwell divider and digit index; both hold their values while halted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         dig_idx <= '0;
      end else if (scan_act) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   // Leading-zero mask: digit i>0 is blanked when it and every digit above it hold zero.
   always_comb begin
      lz_blank = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (shadow_val[4*i +: 4] == 4'h0);
         if (i > 0) lz_blank[i] = zero_run & blank_lz;
      end
   end

   // Output pixel for the current digit/dwell position, with polarity applied before the register.
   always_comb begin
      seg_nxt   = SEG_OFF;
      dp_nxt    = INV;
      dig_nxt   = DIG_OFF;
      cur_nib   = shadow_val[4*dig_idx +: 4];
      guard_act = (div_cnt < GUARD_C);
      frame_nxt = scan_act && (div_cnt == DIV_LAST) && (dig_idx == IDX_LAST);
      if (scan_act && !guard_act) begin
         dig_nxt = (DIG_ONE << dig_idx) ^ DIG_OFF;
         dp_nxt  = shadow_dp[dig_idx] ^ INV;
         seg_nxt = (lz_blank[dig_idx] ? 7'h00 : hex_decode(cur_nib)) ^ SEG_OFF;
      end
   end

   // Registered pin drivers and end-of-frame pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= SEG_OFF;
         dp         <= INV;
         dig_sel    <= DIG_OFF;
         frame_done <= 1'b0;
      end else begin
         seg        <= seg_nxt;
         dp         <= dp_nxt;
         dig_sel    <= dig_nxt;
         frame_done <= frame_nxt;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_display.sv
// Purpose: directed self-checking bench for seven_seg_scan_display (4 digits, 8-cycle dwell, 2-cycle guard).
// Latency: expectations assume outputs one cycle behind the internal dwell position.
// Backpressure: none; stimulus is driven 1 time unit after each rising edge.
module tb_seven_seg_scan_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic        blank_lz = 1'b0;

   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  dig_sel;
   logic        frame_done;
   logic [6:0]  seg_ca;
   logic        dp_ca;
   logic [3:0]  dig_sel_ca;
   logic        frame_done_ca;

   int checks = 0;
   int failures = 0;

   seven_seg_scan_display #(
      .NUM_DIGITS(4), .SCAN_DIV(8), .GUARD(2), .COMMON_ANODE(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp), .dig_sel(dig_sel),
      .frame_done(frame_done)
   );

   seven_seg_scan_display #(
      .NUM_DIGITS(4), .SCAN_DIV(8), .GUARD(2), .COMMON_ANODE(1)
   ) dut_ca (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_ca), .dp(dp_ca), .dig_sel(dig_sel_ca),
      .frame_done(frame_done_ca)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if ({seg, dp, dig_sel, frame_done} !== 13'h0) begin
         failures++;
         $display("FAIL reset_ca0 got=%h want=%h", {seg, dp, dig_sel, frame_done}, 13'h0);
      end
      checks++;
      if ({seg_ca, dp_ca, dig_sel_ca} !== {7'h7F, 1'b1, 4'b1111}) begin
         failures++;
         $display("FAIL reset_ca1 got=%h want=%h", {seg_ca, dp_ca, dig_sel_ca}, {7'h7F, 1'b1, 4'b1111});
      end
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_decode_scan();
      logic [6:0]  tab [4];
      logic [3:0]  dpp;
      logic [11:0] exp_v;
      logic [3:0]  one;
      int d, p;
      tab = '{7'h3F, 7'h71, 7'h4F, 7'h77};
      dpp = 4'b0100;
      value = 16'hA3F0; dp_in = dpp; load = 1'b1;
      tick();
      load = 1'b0;
      checks++;
      if ({seg, dp, dig_sel} !== 12'h0) begin
         failures++;
         $display("FAIL halted_after_load got=%h want=%h", {seg, dp, dig_sel}, 12'h0);
      end
      enable = 1'b1;
      for (int c = 0; c < 32; c++) begin
         tick();
         d = c / 8; p = c % 8;
         one = 4'b0001 << d;
         exp_v = (p >= 2) ? {tab[d], dpp[d], one} : 12'h0;
         checks++;
         if ({seg, dp, dig_sel} !== exp_v) begin
            failures++;
            $display("FAIL decode_scan c=%0d got=%h want=%h", c, {seg, dp, dig_sel}, exp_v);
         end
      end
   endtask

   task automatic test_frame_timing();
      logic exp_fd;
      for (int c = 0; c < 64; c++) begin
         tick();
         exp_fd = ((c % 32) == 31);
         checks++;
         if ({frame_done, frame_done_ca} !== {exp_fd, exp_fd}) begin
            failures++;
            $display("FAIL frame_done c=%0d got=%b want=%b", c, {frame_done, frame_done_ca}, {exp_fd, exp_fd});
         end
      end
   endtask

   task automatic test_halt_resume();
      logic [6:0]  tab [2];
      logic [11:0] exp_v;
      logic [3:0]  one;
      int c, d, p;
      tab = '{7'h3F, 7'h07};
      for (int k = 0; k < 21; k++) tick();
      checks++;
      if ({seg, dp, dig_sel} !== {7'h4F, 1'b1, 4'b0100}) begin
         failures++;
         $display("FAIL pre_halt got=%h want=%h", {seg, dp, dig_sel}, {7'h4F, 1'b1, 4'b0100});
      end
      enable = 1'b0;
      for (int h = 0; h < 20; h++) begin
         tick();
         checks++;
         if ({seg, dp, dig_sel, frame_done} !== 13'h0) begin
            failures++;
            $display("FAIL halt h=%0d got=%h want=%h", h, {seg, dp, dig_sel, frame_done}, 13'h0);
         end
         if (h == 4) begin
            value = 16'h7000; dp_in = 4'b0000; load = 1'b1;
         end
         if (h == 5) load = 1'b0;
      end
      enable = 1'b1;
      for (int j = 0; j < 11; j++) begin
         tick();
         c = 21 + j; d = c / 8; p = c % 8;
         one = 4'b0001 << d;
         exp_v = (p >= 2) ? {tab[d-2], 1'b0, one} : 12'h0;
         checks++;
         if ({seg, dp, dig_sel, frame_done} !== {exp_v, (c == 31)}) begin
            failures++;
            $display("FAIL resume c=%0d got=%h want=%h", c, {seg, dp, dig_sel, frame_done}, {exp_v, (c == 31)});
         end
      end
   endtask

   task automatic test_blank_lz();
      logic [6:0]  d0seg [2];
      logic [15:0] vals [2];
      logic [11:0] exp_v;
      logic [3:0]  one;
      int d, p;
      d0seg = '{7'h6D, 7'h3F};
      vals  = '{16'h0005, 16'h0000};
      blank_lz = 1'b1;
      for (int r = 0; r < 2; r++) begin
         value = vals[r]; dp_in = 4'b0000; load = 1'b1;
         tick();
         load = 1'b0;
         for (int c = 1; c < 32; c++) begin
            tick();
            d = c / 8; p = c % 8;
            one = 4'b0001 << d;
            exp_v = (p >= 2) ? {((d == 0) ? d0seg[r] : 7'h00), 1'b0, one} : 12'h0;
            checks++;
            if ({seg, dp, dig_sel} !== exp_v) begin
               failures++;
               $display("FAIL blank_lz r=%0d c=%0d got=%h want=%h", r, c, {seg, dp, dig_sel}, exp_v);
            end
         end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_polarity();
      logic [11:0] exp_ca, exp_cc;
      value = 16'h0008; dp_in = 4'b0000; load = 1'b1;
      tick();
      load = 1'b0;
      for (int c = 1; c < 8; c++) begin
         tick();
         exp_ca = (c >= 2) ? {7'h00, 1'b1, 4'b1110} : {7'h7F, 1'b1, 4'b1111};
         exp_cc = (c >= 2) ? {7'h7F, 1'b0, 4'b0001} : 12'h0;
         checks++;
         if ({seg_ca, dp_ca, dig_sel_ca} !== exp_ca) begin
            failures++;
            $display("FAIL polarity_ca c=%0d got=%h want=%h", c, {seg_ca, dp_ca, dig_sel_ca}, exp_ca);
         end
         checks++;
         if ({seg, dp, dig_sel} !== exp_cc) begin
            failures++;
            $display("FAIL polarity_cc c=%0d got=%h want=%h", c, {seg, dp, dig_sel}, exp_cc);
         end
      end
   endtask

   task automatic test_async_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({seg, dp, dig_sel, frame_done} !== 13'h0) begin
         failures++;
         $display("FAIL async_rst_out got=%h want=%h", {seg, dp, dig_sel, frame_done}, 13'h0);
      end
      checks++;
      if ({dut.shadow_val, dut.shadow_dp} !== 20'h0) begin
         failures++;
         $display("FAIL async_rst_shadow got=%h want=%h", {dut.shadow_val, dut.shadow_dp}, 20'h0);
      end
      checks++;
      if ({seg_ca, dp_ca, dig_sel_ca} !== {7'h7F, 1'b1, 4'b1111}) begin
         failures++;
         $display("FAIL async_rst_ca got=%h want=%h", {seg_ca, dp_ca, dig_sel_ca}, {7'h7F, 1'b1, 4'b1111});
      end
      #1 rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if ({seg, dp, dig_sel} !== 12'h0) begin
         failures++;
         $display("FAIL first_guard got=%h want=%h", {seg, dp, dig_sel}, 12'h0);
      end
      tick();
      checks++;
      if ({seg, dp, dig_sel} !== {7'h3F, 1'b0, 4'b0001}) begin
         failures++;
         $display("FAIL first_lit got=%h want=%h", {seg, dp, dig_sel}, {7'h3F, 1'b0, 4'b0001});
      end
   endtask

   initial begin
      test_reset();
      test_decode_scan();
      test_frame_timing();
      test_halt_resume();
      test_blank_lz();
      test_polarity();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/seven_seg_scan_display.md
# seven_seg_scan_display

Time-multiplexed driver for an N-digit hexadecimal seven-segment display. It is the parametrised successor to the single-digit, 4-bit combinational decoder on the TinyTapeout top level. It captures a wide value into a shadow register, scans one digit at a time with a programmable dwell, inserts an anti-ghosting blank at each digit change, and optionally suppresses leading zeros. It sits between the CPU's data-memory readout and the `uo_out` and `uio_out` pins.

## Interface
- `NUM_DIGITS`, 4: number of digits, legal range 1..8.
- `SCAN_DIV`, 1024: clock cycles per digit dwell, must be ≥ 2.
- `GUARD`, 16: blank cycles at the start of each dwell, 0 ≤ GUARD < SCAN_DIV.
- `COMMON_ANODE`, 0: 1 inverts `seg`, `dp` and `dig_sel` at the output register.

- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous active-low reset.
- `enable` input 1: 1 = scanning, 0 = scanning halted and display dark.
- `load` input 1: capture `value` and `dp_in` into the shadow register.
- `value` input 4*NUM_DIGITS: nibble i drives digit i, where digit 0 is least significant.
- `dp_in` input NUM_DIGITS: decimal point per digit.
- `blank_lz` input 1: leading-zero blanking enable.
- `seg` output 7: segments with bit0=a through bit6=g, registered.
- `dp` output 1: decimal point, registered.
- `dig_sel` output NUM_DIGITS: one-hot digit enable, registered.
- `frame_done` output 1: one-cycle pulse at the end of each full scan.

## Operation
- **Shadow register**
  - Holds `value` and `dp_in`.
  - Loaded on any rising edge with `load`=1, independent of `enable`.
  - Clears to 0 on reset.
- **Divider**
  - `div_cnt` counts 0..SCAN_DIV-1.
  - On wrap, `dig_idx` increments modulo NUM_DIGITS.
  - `dig_idx` has width max(1, clog2(NUM_DIGITS)).
- **States: SCAN and HALT**
  - `enable`=0 moves to HALT. HALT freezes `div_cnt` and `dig_idx`, and all outputs are inactive.
  - `enable`=1 resumes SCAN from the frozen counts. There is no restart.
- **Per-cycle output computation in SCAN**
  - If `div_cnt` < GUARD, the guard is active: `dig_sel`, `seg` and `dp` are all inactive.
  - Otherwise `dig_sel` is one-hot at `dig_idx`.
  - `seg` is the hex decode of shadow nibble `dig_idx`.
  - `dp` is shadow `dp_in[dig_idx]`.
- **Hex decode (active-high gfedcba)**
  - 0=3F, 1=06, 2=5B, 3=4F
  - 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C
  - C=39, d=5E, E=79, F=71
- **Leading-zero blanking**
  - Applies when `blank_lz`=1.
  - Digit i > 0 is blanked when shadow nibbles i..NUM_DIGITS-1 are all zero. Blanked means `seg` is inactive.
  - A blanked digit keeps its `dig_sel` and `dp`.
  - Digit 0 is never blanked.
- **Output polarity**
  - Inactive means 0 with COMMON_ANODE=0 and 1 with COMMON_ANODE=1.
  - With COMMON_ANODE=1 the whole `seg`/`dp`/`dig_sel` output vector is bitwise inverted.
- **`frame_done`**
  - Asserted for one cycle on the edge where `div_cnt` wraps with `dig_idx`=NUM_DIGITS-1.
  - Never asserted in HALT.
- **NUM_DIGITS=1**
  - `dig_idx` stays 0 and `frame_done` pulses every SCAN_DIV cycles.

## Timing
- **Reset values**
  - `div_cnt`=0, `dig_idx`=0, shadow=0, `frame_done`=0.
  - `seg`, `dp` and `dig_sel` are inactive.
- **Output latency**: outputs are registered and lag `div_cnt`/`dig_idx`/shadow by 1 cycle.
- **Load latency**: `load` at edge t gives the new shadow at t, visible on `seg` at t+1 (edge t+1 output).
- **Load during a dwell**: the current digit updates mid-dwell; there is no tearing protection beyond this.
- **Load and enable on the same edge**: both take effect; the shadow load is not blocked.
- **First lit cycle after reset with `enable`=1**: `div_cnt`=GUARD, so `dig_sel` asserts on the edge after `div_cnt` reaches GUARD.
- **Frame period**: NUM_DIGITS*SCAN_DIV cycles.
- **Reset mid-scan**: all state clears immediately and asynchronously, and outputs go inactive with no clock required.

## Test plan
- **Decode and scan order**: NUM_DIGITS=4, SCAN_DIV=8, GUARD=2; load `value`=16'hA3F0, `dp_in`=4'b0100.
  - Per dwell, `dig_sel` runs 0001→0010→0100→1000.
  - `seg` runs 3F, 71, 4F, 77.
  - `dp`=1 only on digit 2.
  - Each dwell shows 2 inactive cycles, then 6 lit cycles.
- **Leading-zero blanking**: `value`=16'h0005, `blank_lz`=1.
  - Digits 3..1 give `seg`=00 with `dig_sel` still scanning.
  - Digit 0 gives `seg`=6D.
  - With `value`=0, digit 0 gives `seg`=3F.
- **Halt and resume**: deassert `enable` mid-dwell on digit 2 at `div_cnt`=5.
  - Outputs go inactive after 1 cycle.
  - Reassert after 20 cycles; scanning resumes at digit 2, `div_cnt`=5.
  - `frame_done` stays 0 throughout the halt.
- **Frame timing**: SCAN_DIV=8, NUM_DIGITS=4, continuous run; `frame_done` pulses exactly every 32 cycles, 1 cycle wide.
- **Polarity**: COMMON_ANODE=1 with digit 0 = 8.
  - Lit output gives `seg`=00 and `dig_sel`=1110.
  - Reset gives `seg`=7F, `dp`=1, `dig_sel`=1111.
- **Async reset mid-scan**: pulse `rst_n` low between clock edges; outputs go inactive and shadow=0 before the next edge.
